half_fixed_bias_relu_packer: RTL and testbench

Post-processing stage directly downstream of the fixed-point matrix-dot-vector block. Consumes its serial stream of HEIGHT row results (one BITS-wide value per cycle), adds a per-row bias with saturation, applies ReLU, and repacks each complete frame into MULTS-wide beats. The output is shaped as the vector input of the next layer's matrix-dot-vector block. Two result banks are used in ping-pong, so back-to-back frames stream without stalls or backpressure.

---
 rtl/half_fixed_bias_relu_packer.sv | 159 +++++++++++++++
 tb/tb_half_fixed_bias_relu_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_fixed_bias_relu_packer.sv
// Bias-add / saturate / ReLU stage that repacks each HEIGHT-element frame
// from the upstream matrix-dot-vector block into MULTS-wide output beats.
// Two result banks alternate so consecutive frames stream without stalls.
module half_fixed_bias_relu_packer #(
  parameter int unsigned BITS   = 16,
  parameter int unsigned HEIGHT = 10,
  parameter int unsigned MULTS  = 2,
  parameter int unsigned RELU   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_bias,
  input  logic [BITS-1:0] bias_in,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  output logic            out_last,
  output logic [BITS-1:0] vector_out [MULTS]
);

  localparam int unsigned BEATS    = (HEIGHT + MULTS - 1) / MULTS;
  localparam int unsigned IDX_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LAST_IDX = HEIGHT - 1;
  localparam logic [BITS-1:0] SAT_MAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] SAT_MIN = {1'b1, {(BITS-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_EMIT} emit_state_t;

  logic [BITS-1:0]   bias [HEIGHT];
  logic [IDX_W-1:0]  bias_idx;
  logic [BITS-1:0]   bank [2][HEIGHT];
  logic [IDX_W-1:0]  elem_idx;
  logic              wr_bank;
  logic              rd_bank;
  emit_state_t       state;
  logic [BEAT_W-1:0] beat_cnt;

  logic [BITS:0]     sum_c;
  logic [BITS-1:0]   sat_c;
  logic [BITS-1:0]   proc_c;
  logic              launch_c;
  logic              sel_bank_c;
  logic [BITS-1:0]   lane_c [MULTS];

  // Widened bias add, saturation to BITS, optional ReLU clamp.
  // The bias register is read before any same-cycle bias write lands,
  // so a colliding bias update only affects the next frame.
  always_comb begin
    sum_c  = {in_data[BITS-1], in_data} + {bias[elem_idx][BITS-1], bias[elem_idx]};
    sat_c  = sum_c[BITS-1:0];
    if (sum_c[BITS] != sum_c[BITS-1]) begin
      sat_c = sum_c[BITS] ? SAT_MIN : SAT_MAX;
    end
    proc_c = sat_c;
    if ((RELU != 0) && sat_c[BITS-1]) begin
      proc_c = '0;
    end
  end

  // Frame completes when the final element is accepted; emission starts then.
  always_comb begin
    launch_c = in_valid && (elem_idx == IDX_W'(LAST_IDX));
  end

  // Next-beat lane gather; the last element bypasses the bank on launch.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    sel_bank_c = launch_c ? wr_bank : rd_bank;
    for (int j = 0; j < MULTS; j++) begin
      idx       = (launch_c ? 0 : int'(beat_cnt)) * MULTS + j;
      lane_c[j] = '0;
      if (idx < HEIGHT) begin
        if (launch_c && (idx == LAST_IDX)) begin
          lane_c[j] = proc_c;
        end else begin
          lane_c[j] = bank[sel_bank_c][IDX_W'(idx)];
        end
      end
    end
  end

  // Bias register file loaded sequentially; index restarts whenever load drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      bias_idx <= '0;
      for (int i = 0; i < HEIGHT; i++) begin
        bias[i] <= '0;
      end
    end else if (load_bias) begin
      bias[bias_idx] <= bias_in;
      bias_idx       <= (bias_idx == IDX_W'(LAST_IDX)) ? '0 : bias_idx + IDX_W'(1);
    end else begin
      bias_idx <= '0;
    end
  end

  // Element index and ping-pong write bank selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_idx <= '0;
      wr_bank  <= 1'b0;
    end else if (in_valid) begin
      if (launch_c) begin
        elem_idx <= '0;
        wr_bank  <= ~wr_bank;
      end else begin
        elem_idx <= elem_idx + IDX_W'(1);
      end
    end
  end

  // Result bank storage; contents are always written before being read.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      bank[wr_bank][elem_idx] <= proc_c;
    end
  end

  // Emitter: BEATS registered beats per completed frame, out_last on the final one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int j = 0; j < MULTS; j++) begin
        vector_out[j] <= '0;
      end
    end else if (launch_c) begin
      rd_bank    <= wr_bank;
      out_valid  <= 1'b1;
      out_last   <= (BEATS == 1);
      vector_out <= lane_c;
      state      <= (BEATS == 1) ? ST_IDLE : ST_EMIT;
      beat_cnt   <= (BEATS > 1) ? BEAT_W'(1) : '0;
    end else if (state == ST_EMIT) begin
      out_valid  <= 1'b1;
      vector_out <= lane_c;
      if (beat_cnt == BEAT_W'(BEATS - 1)) begin
        out_last <= 1'b1;
        state    <= ST_IDLE;
        beat_cnt <= '0;
      end else begin
        out_last <= 1'b0;
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int j = 0; j < MULTS; j++) begin
        vector_out[j] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_half_fixed_bias_relu_packer.sv
// Directed bench for half_fixed_bias_relu_packer: three instances share stimulus
// (RELU=1 HEIGHT=10, RELU=0 HEIGHT=10, RELU=1 HEIGHT=5).
module tb_half_fixed_bias_relu_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_bias;
  logic [15:0] bias_in;
  logic        in_valid;
  logic [15:0] in_data;

  logic        ov_a, ol_a, ov_b, ol_b, ov_c, ol_c;
  logic [15:0] vo_a [2];
  logic [15:0] vo_b [2];
  logic [15:0] vo_c [2];

  int n_cmp = 0;
  int n_err = 0;
  int stim [20];

  always #5 clk = ~clk;

  half_fixed_bias_relu_packer #(.BITS(16), .HEIGHT(10), .MULTS(2), .RELU(1)) dut_a (
    .clk(clk), .rst(rst), .load_bias(load_bias), .bias_in(bias_in),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_a), .out_last(ol_a), .vector_out(vo_a));

  half_fixed_bias_relu_packer #(.BITS(16), .HEIGHT(10), .MULTS(2), .RELU(0)) dut_b (
    .clk(clk), .rst(rst), .load_bias(load_bias), .bias_in(bias_in),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_b), .out_last(ol_b), .vector_out(vo_b));

  half_fixed_bias_relu_packer #(.BITS(16), .HEIGHT(5), .MULTS(2), .RELU(1)) dut_c (
    .clk(clk), .rst(rst), .load_bias(load_bias), .bias_in(bias_in),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_c), .out_last(ol_c), .vector_out(vo_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; load_bias = 1'b0; in_valid = 1'b0; bias_in = '0; in_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_all(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      load_bias = 1'b1;
      bias_in   = 16'(val);
      step();
    end
    load_bias = 1'b0;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(stim[i]);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ov_a, ol_a, vo_a[0], vo_a[1]} !== 34'd0) begin
      n_err++; $display("FAIL reset_a: got v=%b l=%b %h %h want all 0", ov_a, ol_a, vo_a[0], vo_a[1]);
    end
    n_cmp++;
    if ({ov_b, ol_b, vo_b[0], vo_b[1]} !== 34'd0) begin
      n_err++; $display("FAIL reset_b: got v=%b l=%b %h %h want all 0", ov_b, ol_b, vo_b[0], vo_b[1]);
    end
    n_cmp++;
    if ({ov_c, ol_c, vo_c[0], vo_c[1]} !== 34'd0) begin
      n_err++; $display("FAIL reset_c: got v=%b l=%b %h %h want all 0", ov_c, ol_c, vo_c[0], vo_c[1]);
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 10; i++) stim[i] = i + 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(stim[i]);
      step();
      if (i < 9) begin
        n_cmp++;
        if (ov_a !== 1'b0) begin
          n_err++; $display("FAIL basic_early_valid: elem %0d got %b want 0", i, ov_a);
        end
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (ov_a !== 1'b1 || ol_a !== (k == 4) ||
          vo_a[0] !== 16'(2*k+1) || vo_a[1] !== 16'(2*k+2)) begin
        n_err++;
        $display("FAIL basic_beat%0d: got v=%b l=%b (%0d,%0d) want v=1 l=%b (%0d,%0d)",
                 k, ov_a, ol_a, vo_a[0], vo_a[1], (k == 4), 2*k+1, 2*k+2);
      end
      step();
    end
    n_cmp++;
    if ({ov_a, ol_a, vo_a[0], vo_a[1]} !== 34'd0) begin
      n_err++; $display("FAIL basic_after: got v=%b l=%b %h %h want all 0", ov_a, ol_a, vo_a[0], vo_a[1]);
    end
  endtask

  task automatic test_bias_relu();
    int din   [10] = '{3, 5, 7, 2, 10, 0, 6, 4, 8, 1};
    int exp_a [10] = '{0, 0, 2, 0, 5, 0, 1, 0, 3, 0};
    int exp_b [10] = '{-2, 0, 2, -3, 5, -5, 1, -1, 3, -4};
    do_reset();
    load_all(-5, 10);
    for (int i = 0; i < 10; i++) stim[i] = din[i];
    send(10);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (ov_a !== 1'b1 || vo_a[0] !== 16'(exp_a[2*k]) || vo_a[1] !== 16'(exp_a[2*k+1])) begin
        n_err++;
        $display("FAIL relu_beat%0d: got v=%b (%h,%h) want v=1 (%h,%h)",
                 k, ov_a, vo_a[0], vo_a[1], 16'(exp_a[2*k]), 16'(exp_a[2*k+1]));
      end
      n_cmp++;
      if (ov_b !== 1'b1 || vo_b[0] !== 16'(exp_b[2*k]) || vo_b[1] !== 16'(exp_b[2*k+1])) begin
        n_err++;
        $display("FAIL norelu_beat%0d: got v=%b (%h,%h) want v=1 (%h,%h)",
                 k, ov_b, vo_b[0], vo_b[1], 16'(exp_b[2*k]), 16'(exp_b[2*k+1]));
      end
      step();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load_bias = 1'b1; bias_in = 16'h0100; step();
    bias_in = 16'h8000; step();
    load_bias = 1'b0;
    for (int i = 0; i < 10; i++) stim[i] = 0;
    stim[0] = 32'h7FF0;
    stim[1] = 32'hFF00;
    send(10);
    n_cmp++;
    if (vo_a[0] !== 16'h7FFF || vo_a[1] !== 16'h0000) begin
      n_err++; $display("FAIL sat_relu: got (%h,%h) want (7fff,0000)", vo_a[0], vo_a[1]);
    end
    n_cmp++;
    if (vo_b[0] !== 16'h7FFF || vo_b[1] !== 16'h8000) begin
      n_err++; $display("FAIL sat_norelu: got (%h,%h) want (7fff,8000)", vo_b[0], vo_b[1]);
    end
    for (int k = 0; k < 5; k++) step();
  endtask

  task automatic test_odd();
    do_reset();
    for (int i = 0; i < 5; i++) stim[i] = i + 1;
    send(5);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (ov_c !== 1'b1 || ol_c !== (k == 2) || vo_c[0] !== 16'(2*k+1) ||
          vo_c[1] !== ((k < 2) ? 16'(2*k+2) : 16'd0)) begin
        n_err++;
        $display("FAIL odd_beat%0d: got v=%b l=%b (%0d,%0d) want v=1 l=%b (%0d,%0d)",
                 k, ov_c, ol_c, vo_c[0], vo_c[1], (k == 2), 2*k+1, (k < 2) ? 2*k+2 : 0);
      end
      step();
    end
    n_cmp++;
    if (ov_c !== 1'b0 || ol_c !== 1'b0) begin
      n_err++; $display("FAIL odd_after: got v=%b l=%b want 0 0", ov_c, ol_c);
    end
  endtask

  task automatic test_back_to_back();
    logic        ev, el;
    logic [15:0] e0, e1;
    int          k;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      stim[i]      = i + 1;
      stim[i + 10] = i + 101;
    end
    for (int t = 0; t < 25; t++) begin
      if (t < 20) begin
        in_valid = 1'b1; in_data = 16'(stim[t]);
      end else begin
        in_valid = 1'b0;
      end
      step();
      ev = 1'b0; el = 1'b0; e0 = '0; e1 = '0;
      if (t >= 9 && t <= 13) begin
        k = t - 9; ev = 1'b1; el = (k == 4);
        e0 = 16'(stim[2*k]); e1 = 16'(stim[2*k+1]);
      end else if (t >= 19 && t <= 23) begin
        k = t - 19; ev = 1'b1; el = (k == 4);
        e0 = 16'(stim[10+2*k]); e1 = 16'(stim[10+2*k+1]);
      end
      n_cmp++;
      if (ov_a !== ev || ol_a !== el || vo_a[0] !== e0 || vo_a[1] !== e1) begin
        n_err++;
        $display("FAIL b2b_t%0d: got v=%b l=%b (%0d,%0d) want v=%b l=%b (%0d,%0d)",
                 t, ov_a, ol_a, vo_a[0], vo_a[1], ev, el, e0, e1);
      end
    end
    in_valid = 1'b0;

    // third burst with nonzero bias, reset on its second beat
    load_all(7, 10);
    for (int i = 0; i < 10; i++) stim[i] = i + 201;
    send(10);
    n_cmp++;
    if (ov_a !== 1'b1 || vo_a[0] !== 16'd208 || vo_a[1] !== 16'd209) begin
      n_err++; $display("FAIL third_beat0: got v=%b (%0d,%0d) want v=1 (208,209)", ov_a, vo_a[0], vo_a[1]);
    end
    step();
    n_cmp++;
    if (ov_a !== 1'b1 || vo_a[0] !== 16'd210 || vo_a[1] !== 16'd211) begin
      n_err++; $display("FAIL third_beat1: got v=%b (%0d,%0d) want v=1 (210,211)", ov_a, vo_a[0], vo_a[1]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (ov_a !== 1'b0 || vo_a[0] !== 16'd0 || vo_a[1] !== 16'd0) begin
        n_err++; $display("FAIL abort_c%0d: got v=%b (%0d,%0d) want v=0 (0,0)", i, ov_a, vo_a[0], vo_a[1]);
      end
      step();
    end

    // fresh frame after reset: biases must be back to 0
    for (int i = 0; i < 10; i++) stim[i] = i + 1;
    send(10);
    for (int b = 0; b < 5; b++) begin
      n_cmp++;
      if (ov_a !== 1'b1 || ol_a !== (b == 4) ||
          vo_a[0] !== 16'(2*b+1) || vo_a[1] !== 16'(2*b+2)) begin
        n_err++;
        $display("FAIL fresh_beat%0d: got v=%b l=%b (%0d,%0d) want v=1 l=%b (%0d,%0d)",
                 b, ov_a, ol_a, vo_a[0], vo_a[1], (b == 4), 2*b+1, 2*b+2);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b0; load_bias = 1'b0; bias_in = '0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_bias_relu();
    test_saturation();
    test_odd();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
